// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared FSM state encodings and sizing helper for the
// piso_serializer block.
`default_nettype none

package piso_serializer_pkg;

  typedef logic [1:0] piso_state_t;

  localparam piso_state_t PISO_IDLE   = 2'd0;
  localparam piso_state_t PISO_SHIFT  = 2'd1;
  localparam piso_state_t PISO_PARITY = 2'd2;

  // Bit counter must be able to represent WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_serializer_slice.sv
// piso_serializer_slice: one shift-register bit, a load/shift mux feeding a
// flop with asynchronous active-low clear and a hold (clock-enable) input.
`default_nettype none

module piso_serializer_slice (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hold_i,
  input  logic load_i,
  input  logic load_bit_i,
  input  logic shift_bit_i,
  output logic q_o
);

  logic bit_q;
  logic bit_d;

  assign bit_d = load_i ? load_bit_i : shift_bit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_q <= 1'b0;
    end else if (!hold_i) begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out stage with serial valid and
// end-of-word pulse. Define PISO_PARITY_EN to append an even-parity bit per word.
`default_nettype none

module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iEnb,
  input  logic [WIDTH-1:0] iData,
  input  logic             iValid,
  output logic             oReady,
  output logic             oSerial,
  output logic             oSerValid,
  output logic             oDone
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  piso_state_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] shift_in;
  logic             data_bit;
  logic             in_shift;
  logic             last_data;
  logic             word_end;
  logic             accept;
  logic             sr_hold;

  assign in_shift  = (state_q == PISO_SHIFT);
  assign last_data = in_shift && (count_q == LAST_CNT);
  assign accept    = iValid && oReady;
  assign sr_hold   = iEnb || !(accept || in_shift);

  if (MSB_FIRST != 0) begin : g_msb_first
    assign shift_in = {sr_q[WIDTH-2:0], 1'b0};
    assign data_bit = sr_q[WIDTH-1];
  end else begin : g_lsb_first
    assign shift_in = {1'b0, sr_q[WIDTH-1:1]};
    assign data_bit = sr_q[0];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    piso_serializer_slice u_slice (
      .clk_i       (iClk),
      .rst_ni      (iClr),
      .hold_i      (sr_hold),
      .load_i      (accept),
      .load_bit_i  (iData[i]),
      .shift_bit_i (shift_in[i]),
      .q_o         (sr_q[i])
    );
  end

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;
  logic in_parity;

  assign in_parity = (state_q == PISO_PARITY);
  assign word_end  = in_parity;

  always_comb begin
    parity_d = parity_q;
    if (!iEnb) begin
      if (accept)        parity_d = 1'b0;
      else if (in_shift) parity_d = parity_q ^ data_bit;
    end
  end

  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`else
  assign word_end = last_data;
`endif

  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      state_q <= PISO_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!iEnb) begin
      case (state_q)
        PISO_IDLE: begin
          if (accept) state_d = PISO_SHIFT;
        end
        PISO_SHIFT: begin
          count_d = count_q + 1'b1;
          if (last_data) begin
            count_d = '0;
`ifdef PISO_PARITY_EN
            state_d = PISO_PARITY;
`else
            state_d = accept ? PISO_SHIFT : PISO_IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PISO_PARITY: begin
          state_d = accept ? PISO_SHIFT : PISO_IDLE;
        end
`endif
        default: state_d = PISO_IDLE;
      endcase
      // A newly accepted word always restarts the bit count.
      if (accept) count_d = '0;
    end
  end

  always_comb begin
    oReady    = ((state_q == PISO_IDLE) || word_end) && !iEnb;
    oDone     = word_end && !iEnb;
    oSerValid = 1'b0;
    oSerial   = 1'b0;
    if (in_shift) begin
      oSerValid = !iEnb;
      oSerial   = data_bit;
    end
`ifdef PISO_PARITY_EN
    if (in_parity) begin
      oSerValid = !iEnb;
      oSerial   = parity_q;
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench driving an MSB-first and an LSB-first
// instance with identical stimulus and comparing every cycle against queued bits.
`default_nettype none

module tb_piso_serializer;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic d;
  } exp_bit_t;

  logic         clk;
  logic         iClr;
  logic         iEnb;
  logic [W-1:0] iData;
  logic         iValid;
  logic         rdy_m, ser_m, sv_m, done_m;
  logic         rdy_l, ser_l, sv_l, done_l;

  exp_bit_t qm[$];
  exp_bit_t ql[$];
  int       n_checks;
  int       n_fail;
  logic     acc_flag;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .iClk(clk), .iClr(iClr), .iEnb(iEnb), .iData(iData), .iValid(iValid),
    .oReady(rdy_m), .oSerial(ser_m), .oSerValid(sv_m), .oDone(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .iClk(clk), .iClr(iClr), .iEnb(iEnb), .iData(iData), .iValid(iValid),
    .oReady(rdy_l), .oSerial(ser_l), .oSerValid(sv_l), .oDone(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
`ifdef PISO_PARITY_EN
      qm.push_back('{b: d[W-1-i], d: 1'b0});
      ql.push_back('{b: d[i],     d: 1'b0});
`else
      qm.push_back('{b: d[W-1-i], d: (i == W - 1)});
      ql.push_back('{b: d[i],     d: (i == W - 1)});
`endif
    end
`ifdef PISO_PARITY_EN
    qm.push_back('{b: ^d, d: 1'b1});
    ql.push_back('{b: ^d, d: 1'b1});
`endif
  endtask

  task automatic check_outputs();
    logic exp_rdy;
    logic exp_sv;
    exp_rdy = !iEnb && (qm.size() <= 1);
    exp_sv  = !iEnb && (qm.size() > 0);
    check("ready_msb", rdy_m, exp_rdy);
    check("ready_lsb", rdy_l, exp_rdy);
    check("sval_msb", sv_m, exp_sv);
    check("sval_lsb", sv_l, exp_sv);
    if (exp_sv) begin
      check("ser_msb", ser_m, qm[0].b);
      check("ser_lsb", ser_l, ql[0].b);
      check("done_msb", done_m, qm[0].d);
      check("done_lsb", done_l, ql[0].d);
    end else begin
      check("done_msb", done_m, 1'b0);
      check("done_lsb", done_l, 1'b0);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, release inputs at +1.
  task automatic step();
    logic acc;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    acc_flag = 1'b0;
    if (iClr && !iEnb) begin
      acc = iValid && (qm.size() <= 1);
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) push_word(iData);
      acc_flag = acc;
    end
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    iValid = 1'b1;
    iData  = d;
    n      = 0;
    do begin
      step();
      n++;
    end while (!acc_flag && n < 50);
    if (!acc_flag) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    iValid = 1'b0;
    iData  = $urandom;
    n      = 0;
    while (qm.size() > 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_empty", qm.size(), 0);
    step();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    acc_flag = 1'b0;
    iClr     = 1'b1;
    iEnb     = 1'b0;
    iValid   = 1'b0;
    iData    = '0;

    // Asynchronous reset applied between clock edges.
    #2 iClr = 1'b0;
    #2;
    check("rst_ser", ser_m, 1'b0);
    check("rst_sval", sv_m, 1'b0);
    check("rst_done", done_m, 1'b0);
    check("rst_ready", rdy_m, 1'b1);
    steps(2);
    iClr = 1'b1;
    steps(2);

    send(8'hA5);
    drain();

    send(8'hFF);
    send(8'h00);
    drain();

    send(8'hC3);
    steps(3);
    iEnb = 1'b1;
    steps(3);
    iEnb = 1'b0;
    drain();

    // Valid presented mid-word must not be sampled.
    send(8'h3C);
    iValid = 1'b1;
    iData  = 8'hE7;
    steps(3);
    drain();

    // Reset mid-word aborts the word without oDone.
    send(8'hF0);
    steps(3);
    iClr = 1'b0;
    qm.delete();
    ql.delete();
    #2;
    check("midrst_ser", ser_m, 1'b0);
    check("midrst_sval", sv_m, 1'b0);
    check("midrst_done", done_m, 1'b0);
    check("midrst_ready", rdy_m, 1'b1);
    steps(2);
    iClr = 1'b1;
    send(8'h81);
    drain();

    // Stall while idle with valid: no accept until enabled.
    iEnb   = 1'b1;
    iValid = 1'b1;
    iData  = 8'h5A;
    steps(2);
    iEnb = 1'b0;
    send(8'h5A);
    drain();

`ifdef PISO_PARITY_EN
    send(8'h07);
    send(8'h03);
    drain();
`endif

    for (int k = 0; k < 6; k++) send(W'($urandom));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
